// File: rtl/fluxo_dados_jogo.sv
// fluxo_dados_jogo: datapath beside the game control unit.
// Debounces the play/pass buttons into single-cycle pulses, runs the free
// seed counter, latches the seed, keeps the current-player counter and
// derives the werewolf (lobo) player index from the latched seed.
module fluxo_dados_jogo #(
    parameter int N_JOGADORES = 8,
    parameter int W_J         = 3,
    parameter int SEED_W      = 8,
    parameter int DEBOUNCE    = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              botao_jogar,
    input  logic              botao_passa,
    input  logic              rst_global,
    input  logic              zera_CS,
    input  logic              e_seed_reg,
    input  logic              zera_CJ,
    input  logic              inc_jogador,
    output logic              jogar,
    output logic              passa,
    output logic              CJ_fim,
    output logic [W_J-1:0]    jogador_atual,
    output logic [SEED_W-1:0] seed,
    output logic [W_J-1:0]    lobo_idx,
    output logic              eh_lobo
);

    localparam int CNT_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        SOLTO,
        CONFIRMA_APERTO,
        APERTADO,
        CONFIRMA_SOLTURA
    } estado_t;

    // Seed reduced to a player index; the modulo handles non-power-of-two player counts.
    function automatic logic [W_J-1:0] f_mod_jogadores(input logic [SEED_W-1:0] v);
        logic [SEED_W-1:0] m;
        m = v % SEED_W'(N_JOGADORES);
        return W_J'(m);
    endfunction

    // Bit 0 carries the play button, bit 1 the pass button.
    logic [1:0]        w_raw;
    logic [1:0]        r_sync1;
    logic [1:0]        r_sync2;
    estado_t           r_estado [2];
    logic [CNT_W-1:0]  r_cnt    [2];
    logic [1:0]        r_pulso;

    logic [SEED_W-1:0] r_cs;
    logic [SEED_W-1:0] r_seed;
    logic [W_J-1:0]    r_lobo;
    logic [W_J-1:0]    r_cj;
    logic [SEED_W-1:0] w_seed_prox;

    assign w_raw = {botao_passa, botao_jogar};

    // Two-flop synchronizer for both asynchronous buttons.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM per button; emits one registered pulse when a press is confirmed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                r_estado[i] <= SOLTO;
                r_cnt[i]    <= '0;
            end
            r_pulso <= '0;
        end else begin
            r_pulso <= '0;
            for (int i = 0; i < 2; i++) begin
                case (r_estado[i])
                    SOLTO: begin
                        if (r_sync2[i]) begin
                            r_estado[i] <= CONFIRMA_APERTO;
                            r_cnt[i]    <= CNT_W'(1);
                        end
                    end
                    CONFIRMA_APERTO: begin
                        if (!r_sync2[i]) begin
                            r_estado[i] <= SOLTO;
                        end else if (r_cnt[i] == CNT_W'(DEBOUNCE)) begin
                            r_estado[i] <= APERTADO;
                            r_pulso[i]  <= 1'b1;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                        end
                    end
                    APERTADO: begin
                        if (!r_sync2[i]) begin
                            r_estado[i] <= CONFIRMA_SOLTURA;
                            r_cnt[i]    <= CNT_W'(1);
                        end
                    end
                    CONFIRMA_SOLTURA: begin
                        if (r_sync2[i]) begin
                            r_estado[i] <= APERTADO;
                        end else if (r_cnt[i] == CNT_W'(DEBOUNCE)) begin
                            r_estado[i] <= SOLTO;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_estado[i] <= SOLTO;
                    end
                endcase
            end
        end
    end

    // Free-running seed counter; wraps naturally at 2^SEED_W.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cs <= '0;
        end else if (zera_CS) begin
            r_cs <= '0;
        end else begin
            r_cs <= r_cs + SEED_W'(1);
        end
    end

    // Next seed value shared by seed_reg and lobo_idx so both move on the same edge.
    // The pre-edge counter value is captured even when zera_CS clears it at the same time.
    always_comb begin
        w_seed_prox = r_seed;
        if (rst_global) begin
            w_seed_prox = '0;
        end else if (e_seed_reg) begin
            w_seed_prox = r_cs;
        end
    end

    // Seed register and werewolf index.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_seed <= '0;
            r_lobo <= '0;
        end else begin
            r_seed <= w_seed_prox;
            r_lobo <= f_mod_jogadores(w_seed_prox);
        end
    end

    // Player counter: rst_global beats zera_CJ beats inc_jogador; wraps after the last player.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cj <= '0;
        end else if (rst_global || zera_CJ) begin
            r_cj <= '0;
        end else if (inc_jogador) begin
            if (r_cj == W_J'(N_JOGADORES - 1)) begin
                r_cj <= '0;
            end else begin
                r_cj <= r_cj + W_J'(1);
            end
        end
    end

    assign jogar         = r_pulso[0];
    assign passa         = r_pulso[1];
    assign jogador_atual = r_cj;
    assign seed          = r_seed;
    assign lobo_idx      = r_lobo;
    assign CJ_fim        = (r_cj == W_J'(N_JOGADORES - 1));
    assign eh_lobo       = (r_cj == r_lobo);

endmodule

// File: tb/tb_fluxo_dados_jogo.sv
// Directed testbench for fluxo_dados_jogo (N_JOGADORES=8, W_J=3, SEED_W=8, DEBOUNCE=4).
module tb_fluxo_dados_jogo;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       botao_jogar, botao_passa;
    logic       rst_global, zera_CS, e_seed_reg, zera_CJ, inc_jogador;
    logic       jogar, passa, CJ_fim, eh_lobo;
    logic [2:0] jogador_atual, lobo_idx;
    logic [7:0] seed;

    int n_chk  = 0;
    int n_fail = 0;
    int n_pulsos;

    fluxo_dados_jogo #(
        .N_JOGADORES(8), .W_J(3), .SEED_W(8), .DEBOUNCE(4)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .botao_jogar(botao_jogar), .botao_passa(botao_passa),
        .rst_global(rst_global), .zera_CS(zera_CS), .e_seed_reg(e_seed_reg),
        .zera_CJ(zera_CJ), .inc_jogador(inc_jogador),
        .jogar(jogar), .passa(passa), .CJ_fim(CJ_fim),
        .jogador_atual(jogador_atual), .seed(seed),
        .lobo_idx(lobo_idx), .eh_lobo(eh_lobo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Load the seed register with value v via zera_CS then e_seed_reg.
    task automatic carrega_seed(input int v);
        zera_CS = 1'b1; tick(); zera_CS = 1'b0;
        ticks(v);
        e_seed_reg = 1'b1; tick(); e_seed_reg = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        botao_jogar = 0; botao_passa = 0;
        rst_global = 0; zera_CS = 0; e_seed_reg = 0; zera_CJ = 0; inc_jogador = 0;
        ticks(3);

        // Reset state
        chk("rst_jogar", jogar, 0);
        chk("rst_passa", passa, 0);
        chk("rst_cjfim", CJ_fim, 0);
        chk("rst_jogador", jogador_atual, 0);
        chk("rst_seed", seed, 0);
        chk("rst_lobo", lobo_idx, 0);
        chk("rst_ehlobo", eh_lobo, 1);
        reset_n = 1'b1;
        ticks(2);

        // Held pass button: single pulse 6 edges after the first sampling edge
        botao_passa = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("passa_hold_e%0d", i), passa, (i == 7));
            chk($sformatf("jogar_quiet_e%0d", i), jogar, 0);
        end
        botao_passa = 1'b0;
        n_pulsos = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            n_pulsos += passa;
        end
        chk("passa_release_no_pulse", n_pulsos, 0);

        // 3-cycle glitch: no pulse
        botao_passa = 1'b1;
        ticks(3);
        botao_passa = 1'b0;
        n_pulsos = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            n_pulsos += passa;
        end
        chk("passa_glitch", n_pulsos, 0);

        // Play button; reset mid-press forces a full re-debounce
        botao_jogar = 1'b1;
        n_pulsos = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 7) chk("jogar_pulse_e7", jogar, 1);
            n_pulsos += jogar;
        end
        chk("jogar_single", n_pulsos, 1);
        reset_n = 1'b0;
        ticks(2);
        chk("jogar_in_rst", jogar, 0);
        reset_n = 1'b1;
        n_pulsos = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 7) chk("jogar_redebounce_e7", jogar, 1);
            n_pulsos += jogar;
        end
        chk("jogar_redebounce_count", n_pulsos, 1);
        botao_jogar = 1'b0;
        ticks(12);

        // Seed counter
        zera_CS = 1'b1; ticks(2); zera_CS = 1'b0;
        ticks(37);
        e_seed_reg = 1'b1; tick(); e_seed_reg = 1'b0;
        chk("seed_37", seed, 37);
        chk("lobo_37", lobo_idx, 5);
        carrega_seed(300);
        chk("seed_wrap_44", seed, 44);
        chk("lobo_44", lobo_idx, 4);

        // Player counter
        zera_CJ = 1'b1; tick(); zera_CJ = 1'b0;
        chk("cj_zero", jogador_atual, 0);
        inc_jogador = 1'b1; ticks(7); inc_jogador = 1'b0;
        chk("cj_7", jogador_atual, 7);
        chk("cjfim_7", CJ_fim, 1);
        inc_jogador = 1'b1; tick(); inc_jogador = 1'b0;
        chk("cj_wrap", jogador_atual, 0);
        chk("cjfim_wrap", CJ_fim, 0);

        // Priority: rst_global over zera_CJ/inc and over e_seed_reg
        inc_jogador = 1'b1; ticks(3); inc_jogador = 1'b0;
        chk("cj_3", jogador_atual, 3);
        rst_global = 1; zera_CJ = 1; inc_jogador = 1; e_seed_reg = 1;
        tick();
        rst_global = 0; zera_CJ = 0; inc_jogador = 0; e_seed_reg = 0;
        chk("prio_cj", jogador_atual, 0);
        chk("prio_seed", seed, 0);
        chk("prio_lobo", lobo_idx, 0);
        // zera_CJ beats inc_jogador
        inc_jogador = 1'b1; ticks(2);
        zera_CJ = 1'b1; tick(); zera_CJ = 1'b0; inc_jogador = 1'b0;
        chk("prio_zeracj", jogador_atual, 0);

        // e_seed_reg with zera_CS at CS=12: seed gets 12, counter clears
        zera_CS = 1'b1; tick(); zera_CS = 1'b0;
        ticks(12);
        e_seed_reg = 1'b1; zera_CS = 1'b1; tick(); e_seed_reg = 1'b0; zera_CS = 1'b0;
        chk("seed_12", seed, 12);
        chk("lobo_12", lobo_idx, 4);
        ticks(5);
        e_seed_reg = 1'b1; tick(); e_seed_reg = 1'b0;
        chk("cs_cleared", seed, 5);

        // eh_lobo sweep with seed 13 -> lobo 5
        carrega_seed(13);
        chk("seed_13", seed, 13);
        chk("lobo_13", lobo_idx, 5);
        zera_CJ = 1'b1; tick(); zera_CJ = 1'b0;
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("sweep_cj%0d", j), jogador_atual, j);
            chk($sformatf("sweep_ehlobo%0d", j), eh_lobo, (j == 5));
            chk($sformatf("sweep_cjfim%0d", j), CJ_fim, (j == 7));
            inc_jogador = 1'b1; tick(); inc_jogador = 1'b0;
        end

        // Asynchronous reset mid-operation
        inc_jogador = 1'b1; ticks(3); inc_jogador = 1'b0;
        botao_jogar = 1'b1;
        ticks(3);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_jogador", jogador_atual, 0);
        chk("mid_rst_seed", seed, 0);
        chk("mid_rst_lobo", lobo_idx, 0);
        chk("mid_rst_cjfim", CJ_fim, 0);
        chk("mid_rst_ehlobo", eh_lobo, 1);
        n_pulsos = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_pulsos += jogar + passa;
        end
        botao_jogar = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_pulsos += jogar + passa;
        end
        chk("mid_rst_no_pulse", n_pulsos, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
